// File: rtl/axi_traffic_gen.sv
// -----------------------------------------------------------------------------
// axi_traffic_gen
//
// AXI master traffic generator. A run writes NUM_BURSTS incrementing bursts
// (BURST_LEN+1 beats each) starting at ADDR_BASE, stepping ADDR_STEP per
// burst, then reads the same bursts back and counts mismatches. MODE 0 does
// all writes and then all reads; MODE 1 writes burst k and reads it back
// before moving on to burst k+1. Only one burst is in flight at any time and
// write and read activity never overlap.
//
// Write beat i of the burst at address A carries (A + i), resized to
// DATA_WIDTH. Reads are checked against the same pattern.
//
// Ports
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   start           : run request, only sampled while idle
//   busy, done      : busy outside IDLE; done sticky until the next start
//   err_cnt         : saturating count of read data / rlast faults
//   aw* / w* / b*   : AXI write address, data and response channels
//   ar* / r*        : AXI read address and data channels
// -----------------------------------------------------------------------------
module axi_traffic_gen #(
    parameter int         ADDR_WIDTH = 16,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] BURST_LEN  = 8'd7,
    parameter int         NUM_BURSTS = 4,
    parameter int         ADDR_BASE  = 16,
    parameter int         ADDR_STEP  = 16,
    parameter int         MODE       = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,

    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,

    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wlast,

    input  logic                  bvalid,
    output logic                  bready,

    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,

    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rlast
);

    // Top-level phases: WR is covered by S_AW/S_W/S_B, RD by S_AR/S_R.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam int BCW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BCW-1:0] LAST_BURST = BCW'(NUM_BURSTS - 1);

    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(ADDR_STEP);

    // Pattern sum is formed wide enough that A + beat never wraps before
    // being resized to the data width.
    localparam int PW = ADDR_WIDTH + 9;

    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0]            beat
    );
        logic [PW-1:0] s;
        s = PW'(a) + PW'(beat);
        return DATA_WIDTH'(s);
    endfunction

    function automatic logic [15:0] sat_add(
        input logic [15:0] cnt,
        input logic [1:0]  inc
    );
        logic [16:0] s;
        s = {1'b0, cnt} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [BCW-1:0]        burst_q, burst_d;
    logic [7:0]            beat_q,  beat_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [15:0]           err_q,   err_d;
    logic                  done_q,  done_d;

    logic                  last_beat;
    logic                  rd_mismatch;
    logic                  rd_last_err;
    logic [1:0]            rd_inc;

    assign last_beat   = (beat_q == BURST_LEN);
    assign rd_mismatch = (rdata != pattern(addr_q, beat_q));
    // rlast must be high exactly on the final beat; either direction of
    // disagreement is one fault, and the burst still ends on the final beat.
    assign rd_last_err = last_beat ? !rlast : rlast;
    assign rd_inc      = {1'b0, rd_mismatch} + {1'b0, rd_last_err};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_AW;
                    addr_d  = BASE_A;
                    burst_d = '0;
                    beat_d  = 8'd0;
                    err_d   = 16'd0;
                    done_d  = 1'b0;
                end
            end

            S_AW: begin
                if (awready) begin
                    state_d = S_W;
                    beat_d  = 8'd0;
                    wdata_d = pattern(addr_q, 8'd0);
                end
            end

            S_W: begin
                if (wready) begin
                    if (last_beat) begin
                        state_d = S_B;
                        beat_d  = 8'd0;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        wdata_d = pattern(addr_q, beat_q + 8'd1);
                    end
                end
            end

            S_B: begin
                if (bvalid) begin
                    if (MODE == 1) begin
                        // Read back the burst just written, same address.
                        state_d = S_AR;
                    end else if (burst_q == LAST_BURST) begin
                        state_d = S_AR;
                        burst_d = '0;
                        addr_d  = BASE_A;
                    end else begin
                        state_d = S_AW;
                        burst_d = burst_q + BCW'(1);
                        addr_d  = addr_q + STEP_A;
                    end
                end
            end

            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                    beat_d  = 8'd0;
                end
            end

            S_R: begin
                if (rvalid) begin
                    err_d = sat_add(err_q, rd_inc);
                    if (last_beat) begin
                        beat_d = 8'd0;
                        if (burst_q == LAST_BURST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = (MODE == 1) ? S_AW : S_AR;
                            burst_d = burst_q + BCW'(1);
                            addr_d  = addr_q + STEP_A;
                        end
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_A;
            burst_q <= '0;
            beat_q  <= 8'd0;
            wdata_q <= '0;
            err_q   <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Channel controls decode straight from the state register, so address,
    // data and last stay frozen for as long as a handshake is stalled.
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err_cnt = err_q;

    assign awvalid = (state_q == S_AW);
    assign awaddr  = addr_q;
    assign awlen   = BURST_LEN;

    assign wvalid  = (state_q == S_W);
    assign wdata   = wdata_q;
    assign wlast   = (state_q == S_W) && last_beat;

    assign bready  = (state_q == S_B);

    assign arvalid = (state_q == S_AR);
    assign araddr  = addr_q;
    assign arlen   = BURST_LEN;

    assign rready  = (state_q == S_R);

endmodule

// File: tb/tb_axi_traffic_gen.sv
module tb_axi_traffic_gen;

    // Channel codes used in the expected-event queues.
    localparam int CH_AW = 0, CH_W = 1, CH_B = 2, CH_AR = 3, CH_R = 4, CH_DONE = 5;

    typedef struct {
        int          ch;
        logic [63:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: defaults (MODE 0, 4 bursts x 8 beats from 16 step 16)
    logic        start0, busy0, done0;
    logic [15:0] err0;
    logic        awvalid0, awready0, wvalid0, wready0, wlast0, bvalid0, bready0;
    logic        arvalid0, arready0, rvalid0, rready0, rlast0;
    logic [15:0] awaddr0, araddr0;
    logic [7:0]  awlen0, arlen0;
    logic [31:0] wdata0, rdata0;

    // Instance 1: MODE 1, 3 single-beat bursts, 8-bit address wrapping from F0
    logic        start1, busy1, done1;
    logic [15:0] err1;
    logic        awvalid1, awready1, wvalid1, wready1, wlast1, bvalid1, bready1;
    logic        arvalid1, arready1, rvalid1, rready1, rlast1;
    logic [7:0]  awaddr1, araddr1, awlen1, arlen1;
    logic [7:0]  wdata1, rdata1;

    axi_traffic_gen u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .err_cnt(err0),
        .awvalid(awvalid0), .awready(awready0), .awaddr(awaddr0), .awlen(awlen0),
        .wvalid(wvalid0), .wready(wready0), .wdata(wdata0), .wlast(wlast0),
        .bvalid(bvalid0), .bready(bready0),
        .arvalid(arvalid0), .arready(arready0), .araddr(araddr0), .arlen(arlen0),
        .rvalid(rvalid0), .rready(rready0), .rdata(rdata0), .rlast(rlast0)
    );

    axi_traffic_gen #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .BURST_LEN(8'd0), .NUM_BURSTS(3),
        .ADDR_BASE(8'hF0), .ADDR_STEP(16), .MODE(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .err_cnt(err1),
        .awvalid(awvalid1), .awready(awready1), .awaddr(awaddr1), .awlen(awlen1),
        .wvalid(wvalid1), .wready(wready1), .wdata(wdata1), .wlast(wlast1),
        .bvalid(bvalid1), .bready(bready1),
        .arvalid(arvalid1), .arready(arready1), .araddr(araddr1), .arlen(arlen1),
        .rvalid(rvalid1), .rready(rready1), .rdata(rdata1), .rlast(rlast1)
    );

    int  checks = 0;
    int  errors = 0;
    int  overlap0 = 0;
    bit  stall_en = 0;
    bit  fault_en = 0;
    ev_t q0[$];
    ev_t q1[$];
    logic [31:0] mem0 [int];
    logic [7:0]  mem1 [int];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int inst, input int ch, input logic [63:0] val);
        ev_t e;
        e.ch  = ch;
        e.val = val;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic expect_ev(input int inst, input int ch, input logic [63:0] val, input string nm);
        ev_t e;
        int  n;
        n = (inst == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event value %0h, expected no further event", nm, val);
            return;
        end
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
        chk({nm, "_channel"}, 64'(ch), 64'(e.ch));
        if (e.ch == ch && ch != CH_B && ch != CH_R)
            chk(nm, val, e.val);
    endtask

    // Expected event stream of one full default run on instance 0.
    task automatic push_run0(input int exp_err);
        logic [15:0] a [4];
        a = '{16'd16, 16'd32, 16'd48, 16'd64};
        for (int k = 0; k < 4; k++) begin
            push(0, CH_AW, 64'(a[k]));
            for (int i = 0; i < 8; i++)
                push(0, CH_W, {31'd0, (i == 7), 32'(a[k] + 16'(i))});
            push(0, CH_B, 64'd0);
        end
        for (int k = 0; k < 4; k++) begin
            push(0, CH_AR, 64'(a[k]));
            for (int i = 0; i < 8; i++) push(0, CH_R, 64'd0);
        end
        push(0, CH_DONE, 64'(exp_err));
    endtask

    task automatic push_run1();
        logic [7:0] a [3];
        a = '{8'hF0, 8'h00, 8'h10};
        for (int k = 0; k < 3; k++) begin
            push(1, CH_AW, 64'(a[k]));
            push(1, CH_W, {31'd0, 1'b1, 24'd0, a[k]});
            push(1, CH_B, 64'd0);
            push(1, CH_AR, 64'(a[k]));
            push(1, CH_R, 64'd0);
        end
        push(1, CH_DONE, 64'd0);
    endtask

    task automatic pulse(input int inst);
        @(posedge clk); #1;
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (inst == 0) ? done0 : done1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: done not seen within %0d cycles, expected done=1", nm, budget);
        end
    endtask

    // ---------------- memory model, instance 0 ----------------
    initial begin : slave0
        bit          hs_aw, hs_w, hs_b, hs_ar, hs_r, b_pend, rd_act;
        int          wr_beat, rd_beat, rd_burst;
        logic [15:0] wr_addr, rd_addr;
        b_pend = 0; rd_act = 0; wr_beat = 0; rd_beat = 0; wr_addr = '0; rd_addr = '0;
        forever begin
            @(negedge clk);
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
            if (rst) begin
                b_pend = 0; rd_act = 0; wr_beat = 0; rd_beat = 0;
            end else begin
                hs_aw = awvalid0 && awready0;
                hs_w  = wvalid0 && wready0;
                hs_b  = bvalid0 && bready0;
                hs_ar = arvalid0 && arready0;
                hs_r  = rvalid0 && rready0;
                if (hs_aw) begin wr_addr = awaddr0; wr_beat = 0; end
                if (hs_w) begin
                    mem0[int'(wr_addr) * 256 + wr_beat] = wdata0;
                    wr_beat++;
                    if (wlast0) b_pend = 1;
                end
                if (hs_ar) begin rd_addr = araddr0; rd_beat = 0; rd_act = 1; end
                if (hs_r) begin
                    rd_beat++;
                    if (rd_beat == 8) rd_act = 0;
                end
            end
            @(posedge clk); #1;
            awready0 = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            wready0  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            arready0 = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hs_b) b_pend = 0;
            if (!b_pend) bvalid0 = 1'b0;
            else if (!bvalid0) bvalid0 = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_act) begin
                rvalid0  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                rd_burst = (int'(rd_addr) - 16) / 16;
                rdata0   = mem0.exists(int'(rd_addr) * 256 + rd_beat) ?
                           mem0[int'(rd_addr) * 256 + rd_beat] : 32'hDEAD_BEEF;
                if (fault_en && rd_burst == 1 && rd_beat == 3) rdata0 = rdata0 ^ 32'h1;
                rlast0 = (rd_beat == 7) || (fault_en && rd_burst == 2 && rd_beat == 5);
            end else begin
                rvalid0 = 1'b0;
                rlast0  = 1'b0;
            end
        end
    end

    // ---------------- memory model, instance 1 ----------------
    initial begin : slave1
        bit         hs_w, hs_b, hs_ar, hs_r, b_pend, rd_act;
        logic [7:0] wr_addr, rd_addr;
        b_pend = 0; rd_act = 0; wr_addr = '0; rd_addr = '0;
        forever begin
            @(negedge clk);
            hs_b = 0;
            if (rst) begin
                b_pend = 0; rd_act = 0;
            end else begin
                hs_w  = wvalid1 && wready1;
                hs_b  = bvalid1 && bready1;
                hs_ar = arvalid1 && arready1;
                hs_r  = rvalid1 && rready1;
                if (awvalid1 && awready1) wr_addr = awaddr1;
                if (hs_w) begin mem1[int'(wr_addr)] = wdata1; if (wlast1) b_pend = 1; end
                if (hs_ar) begin rd_addr = araddr1; rd_act = 1; end
                if (hs_r) rd_act = 0;
            end
            @(posedge clk); #1;
            if (hs_b) b_pend = 0;
            bvalid1 = b_pend;
            rvalid1 = rd_act;
            rdata1  = mem1.exists(int'(rd_addr)) ? mem1[int'(rd_addr)] : 8'hEE;
            rlast1  = rd_act;
        end
    end

    // ---------------- monitor, instance 0 ----------------
    initial begin : mon0
        bit          pa, pw, par, pd;
        logic [15:0] paddr, paraddr;
        logic [31:0] pwdata;
        logic        pwlast;
        pa = 0; pw = 0; par = 0; pd = 0; paddr = '0; paraddr = '0; pwdata = '0; pwlast = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pa = 0; pw = 0; par = 0; pd = 0;
                continue;
            end
            if (pa)  chk("aw_hold", {47'd0, awvalid0, awaddr0}, {47'd0, 1'b1, paddr});
            if (pw)  chk("w_hold", {30'd0, wvalid0, wlast0, wdata0}, {30'd0, 1'b1, pwlast, pwdata});
            if (par) chk("ar_hold", {47'd0, arvalid0, araddr0}, {47'd0, 1'b1, paraddr});
            if ((awvalid0 || wvalid0 || bready0) && (arvalid0 || rready0)) overlap0++;
            if (awvalid0 && awready0) begin
                expect_ev(0, CH_AW, 64'(awaddr0), "aw0");
                chk("awlen0", 64'(awlen0), 64'd7);
            end
            if (wvalid0 && wready0) expect_ev(0, CH_W, {31'd0, wlast0, wdata0}, "w0");
            if (bvalid0 && bready0) expect_ev(0, CH_B, 64'd0, "b0");
            if (arvalid0 && arready0) begin
                expect_ev(0, CH_AR, 64'(araddr0), "ar0");
                chk("arlen0", 64'(arlen0), 64'd7);
            end
            if (rvalid0 && rready0) expect_ev(0, CH_R, 64'd0, "r0");
            if (done0 && !pd) expect_ev(0, CH_DONE, 64'(err0), "err_cnt0");
            pa = awvalid0 && !awready0;  paddr = awaddr0;
            pw = wvalid0 && !wready0;    pwdata = wdata0; pwlast = wlast0;
            par = arvalid0 && !arready0; paraddr = araddr0;
            pd = done0;
        end
    end

    // ---------------- monitor, instance 1 ----------------
    initial begin : mon1
        bit pd;
        pd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin pd = 0; continue; end
            if (awvalid1 && awready1) expect_ev(1, CH_AW, 64'(awaddr1), "aw1");
            if (wvalid1 && wready1)   expect_ev(1, CH_W, {31'd0, wlast1, 24'd0, wdata1}, "w1");
            if (bvalid1 && bready1)   expect_ev(1, CH_B, 64'd0, "b1");
            if (arvalid1 && arready1) expect_ev(1, CH_AR, 64'(araddr1), "ar1");
            if (rvalid1 && rready1)   expect_ev(1, CH_R, 64'd0, "r1");
            if (done1 && !pd)         expect_ev(1, CH_DONE, 64'(err1), "err_cnt1");
            pd = done1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : main
        bit found;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        awready0 = 0; wready0 = 0; arready0 = 0; bvalid0 = 0; rvalid0 = 0; rdata0 = '0; rlast0 = 0;
        awready1 = 1; wready1 = 1; arready1 = 1; bvalid1 = 0; rvalid1 = 0; rdata1 = '0; rlast1 = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_err", 64'(err0), 64'd0);
        chk("rst_valids", {59'd0, awvalid0, wvalid0, bready0, arvalid0, rready0}, 64'd0);
        chk("rst_awaddr", 64'(awaddr0), 64'd16);
        chk("rst_araddr", 64'(araddr0), 64'd16);
        chk("rst_awlen", 64'(awlen0), 64'd7);
        chk("rst_wdata", 64'(wdata0), 64'd0);
        chk("rst_awaddr1", 64'(awaddr1), 64'hF0);
        chk("rst_arlen1", 64'(arlen1), 64'd0);

        // Run 1: zero-wait memory, plus a start pulse while busy that must be ignored
        push_run0(0);
        pulse(0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_run", 64'(busy0), 64'd1);
        pulse(0);
        wait_done(0, 2000, "run1");
        repeat (3) @(negedge clk);
        chk("done_sticky", 64'(done0), 64'd1);
        chk("busy_after_done", 64'(busy0), 64'd0);
        chk("run1_drained", 64'(q0.size()), 64'd0);

        // Run 2: random ready/valid stalls on every channel
        stall_en = 1;
        push_run0(0);
        pulse(0);
        wait_done(0, 5000, "run2");
        stall_en = 0;
        repeat (2) @(negedge clk);
        chk("run2_drained", 64'(q0.size()), 64'd0);

        // Run 3: corrupt beat 3 of burst 1, early rlast on beat 5 of burst 2
        fault_en = 1;
        push_run0(2);
        pulse(0);
        wait_done(0, 2000, "run3");
        fault_en = 0;
        repeat (2) @(negedge clk);
        chk("run3_drained", 64'(q0.size()), 64'd0);
        chk("run3_err_hold", 64'(err0), 64'd2);

        // Run 4: reset while beat 4 of the first write burst is presented
        push(0, CH_AW, 64'd16);
        for (int i = 0; i < 4; i++) push(0, CH_W, 64'(16 + i));
        pulse(0);
        @(negedge clk);
        chk("err_clear_on_start", 64'(err0), 64'd0);
        chk("done_clear_on_start", 64'(done0), 64'd0);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (wvalid0 && wready0 && wdata0 == 32'd19) found = 1;
            else @(negedge clk);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL run4_beat3: beat 3 not seen within 500 cycles, expected wdata 13");
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_valids", {59'd0, awvalid0, wvalid0, bready0, arvalid0, rready0}, 64'd0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_wdata", 64'(wdata0), 64'd0);
        chk("midrst_awaddr", 64'(awaddr0), 64'd16);
        chk("run4_drained", 64'(q0.size()), 64'd0);
        repeat (5) @(negedge clk);
        chk("no_resume", 64'(busy0), 64'd0);

        // Run 5: fresh start after reset begins again from burst 0
        push_run0(0);
        pulse(0);
        wait_done(0, 2000, "run5");
        repeat (2) @(negedge clk);
        chk("run5_drained", 64'(q0.size()), 64'd0);
        chk("no_wr_rd_overlap", 64'(overlap0), 64'd0);

        // Instance 1: alternating mode, single-beat bursts, address wrap
        push_run1();
        pulse(1);
        wait_done(1, 500, "run_mode1");
        repeat (2) @(negedge clk);
        chk("mode1_drained", 64'(q1.size()), 64'd0);
        chk("mode1_done", 64'(done1), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_traffic_gen.md
AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of awaddr/araddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of wdata/rdata, minimum 8.
REQ-003 SHALL have parameter BURST_LEN, default 8'd7: AXI len value; beats per burst = BURST_LEN+1, range 0..255.
REQ-004 SHALL have parameter NUM_BURSTS, default 4: bursts per run, minimum 1.
REQ-005 SHALL have parameter ADDR_BASE, default 16: address of burst 0.
REQ-006 SHALL have parameter ADDR_STEP, default 16: address increment between bursts.
REQ-007 SHALL have parameter MODE, default 0: 0 = all writes then all reads; 1 = write burst k, then read burst k, alternating.
REQ-008 SHALL have ports: clk in 1, single clock, all logic on rising edge.
REQ-009 SHALL have ports: rst in 1, reset, synchronous, active-high.
REQ-010 SHALL have ports: start in 1, run request, sampled only in IDLE; busy out 1; done out 1, sticky until next start; err_cnt out 16, read-mismatch count.
REQ-011 SHALL have ports: awvalid out 1, awready in 1, awaddr out ADDR_WIDTH, awlen out 8.
REQ-012 SHALL have ports: wvalid out 1, wready in 1, wdata out DATA_WIDTH, wlast out 1, bvalid in 1, bready out 1.
REQ-013 SHALL have ports: arvalid out 1, arready in 1, araddr out ADDR_WIDTH, arlen out 8, rvalid in 1, rready out 1, rdata in DATA_WIDTH, rlast in 1.

Function
REQ-014 SHALL implement top FSM IDLE -> WR -> RD -> DONE. MODE 0: WR repeats NUM_BURSTS times, then RD repeats NUM_BURSTS times. MODE 1: WR/RD alternate per burst. DONE -> IDLE after 1 cycle with done set.
REQ-015 SHALL compute burst k address as ADDR_BASE + k*ADDR_STEP modulo 2^ADDR_WIDTH (silent wrap); read burst k uses same address as write burst k.
REQ-016 SHALL define write data for burst address A, beat i as (A + i), zero-extended or truncated to DATA_WIDTH.
REQ-017 SHALL run write sub-FSM AW -> W -> B: awvalid asserted the cycle after WR entry; awaddr/awlen held stable until awvalid&awready.
REQ-018 SHALL assert wvalid in W; beat index advances only on wvalid&wready; wdata/wlast held stable while wvalid&!wready; wlast=1 exactly on beat BURST_LEN.
REQ-019 SHALL assert bready only in B; burst complete on bvalid&bready; bresp not examined.
REQ-020 SHALL run read sub-FSM AR -> R: arvalid held with stable araddr/arlen=BURST_LEN until arready.
REQ-021 SHALL keep rready=1 throughout R; on each rvalid compare rdata with expected pattern, beat i.
REQ-022 SHALL count as one error each: a data mismatch; rlast=1 on beat != BURST_LEN; rlast=0 on beat BURST_LEN (burst still ends there). Two faults on the same beat add 2.
REQ-023 SHALL saturate err_cnt at 16'hFFFF; err_cnt cleared when start is accepted.
REQ-024 SHALL keep at most one write and one read burst outstanding, never both at once (no overlap of WR and RD).
REQ-025 SHALL assert busy in every state except IDLE; start while busy SHALL be ignored.
REQ-026 SHALL, for BURST_LEN=0, assert wlast on the first and only beat.

Reset
REQ-027 SHALL on rst=1 at any clock edge, including mid-burst, force IDLE; awvalid, wvalid, bready, arvalid, rready, busy, done = 0; err_cnt=0; burst/beat counters=0; wdata=0; awaddr=araddr=ADDR_BASE; awlen=arlen=BURST_LEN.
REQ-028 SHALL not resume an interrupted run after reset; a new start is required.

Verification
REQ-029 Defaults, MODE 0, zero-wait memory model: start pulse -> 4 write bursts at 16,32,48,64, each 8 beats with wdata A..A+7; then 4 reads; done=1, err_cnt=0.
REQ-030 Random wready/awready/arready stalls: wdata/wlast/awaddr stable during stalls; no skipped or duplicated beats.
REQ-031 Model corrupts beat 3 of read burst 1: err_cnt=1; also rlast early on beat 5 of burst 2: err_cnt=2.
REQ-032 MODE 1, NUM_BURSTS=3: channel order AW,W,B,AR,R repeated 3 times; no arvalid before previous bvalid.
REQ-033 ADDR_WIDTH=8, ADDR_BASE=8'hF0, ADDR_STEP=16, NUM_BURSTS=3: addresses F0,00,10.
REQ-034 rst asserted during W beat 4: next cycle all valids 0, busy 0; new start begins again from burst 0 at ADDR_BASE.
